// File: rtl/frame_maker_top.sv
// CAN bus framing tracker: integration, idle, frame, intermission, overload/error flags and delimiter.
// Latency: isStart/endOverload are registered, so they rise on the sample point after the triggering bit.
// Backpressure: none; the block advances one bit per samplePoint and cannot stall.
module frame_maker_top #(
  parameter int INTEG_BITS  = 11,
  parameter int DELIM_BITS  = 8,
  parameter int INTERM_BITS = 3
) (
  input  logic samplePoint,
  input  logic reset,
  input  logic canRX,
  input  logic frameReady,
  input  logic isError,
  output logic endOverload,
  output logic isStart
);

  typedef enum logic [2:0] {
    ST_INTEGRATE    = 3'd0,
    ST_IDLE         = 3'd1,
    ST_FRAME        = 3'd2,
    ST_INTERMISSION = 3'd3,
    ST_OVL_FLAG     = 3'd4,
    ST_ERR_FLAG     = 3'd5,
    ST_DELIM        = 3'd6
  } state_t;

  // Terminal counts, as 4-bit values so they compare directly with the counter.
  localparam logic [3:0] INTEG_LAST  = 4'(INTEG_BITS);
  localparam logic [3:0] DELIM_LAST  = 4'(DELIM_BITS);
  localparam logic [3:0] INTERM_LAST = 4'(INTERM_BITS);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  // Remembers which flag state led into DELIM, so a dominant bit there returns to it.
  logic       from_err_q, from_err_d;
  logic       is_start_q, is_start_d;
  logic       end_ovl_q, end_ovl_d;
  logic [3:0] cnt_inc;

  // Saturating increment: the counter holds at 15 instead of wrapping.
  always_comb begin
    cnt_inc = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;
  end

  // Next-state, counter and pulse decode for each bus phase.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    from_err_d = from_err_q;
    is_start_d = 1'b0;
    end_ovl_d  = 1'b0;
    unique case (state_q)
      ST_INTEGRATE: begin
        if (!canRX) begin
          cnt_d = 4'd0;
        end else if (cnt_inc == INTEG_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_IDLE: begin
        if (!canRX) begin
          state_d    = ST_FRAME;
          cnt_d      = 4'd0;
          is_start_d = 1'b1;
        end
      end
      ST_FRAME: begin
        if (isError) begin
          state_d = ST_ERR_FLAG;
          cnt_d   = 4'd0;
        end else if (frameReady) begin
          state_d = ST_INTERMISSION;
          cnt_d   = 4'd0;
        end
      end
      ST_INTERMISSION: begin
        // cnt_q counts recessive intermission bits already seen; cnt_inc is the current bit index.
        if (isError) begin
          state_d = ST_ERR_FLAG;
          cnt_d   = 4'd0;
        end else if (!canRX) begin
          cnt_d = 4'd0;
          if (cnt_inc >= INTERM_LAST) begin
            // Dominant in the last intermission bit is a start-of-frame.
            state_d    = ST_FRAME;
            is_start_d = 1'b1;
          end else begin
            state_d = ST_OVL_FLAG;
          end
        end else if (cnt_inc >= INTERM_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_OVL_FLAG, ST_ERR_FLAG: begin
        if (isError && state_q == ST_OVL_FLAG) begin
          state_d = ST_ERR_FLAG;
          cnt_d   = 4'd0;
        end else if (canRX) begin
          // This recessive bit is already the first delimiter bit.
          state_d    = ST_DELIM;
          cnt_d      = 4'd1;
          from_err_d = (state_q == ST_ERR_FLAG);
        end
      end
      ST_DELIM: begin
        if (isError) begin
          state_d = ST_ERR_FLAG;
          cnt_d   = 4'd0;
        end else if (!canRX) begin
          state_d = from_err_q ? ST_ERR_FLAG : ST_OVL_FLAG;
          cnt_d   = 4'd0;
        end else if (cnt_inc == DELIM_LAST) begin
          state_d   = ST_INTERMISSION;
          cnt_d     = 4'd0;
          end_ovl_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ST_INTEGRATE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State, counter and registered pulses; reset wins over every input.
  always_ff @(posedge samplePoint) begin
    if (reset) begin
      state_q    <= ST_INTEGRATE;
      cnt_q      <= 4'd0;
      from_err_q <= 1'b0;
      is_start_q <= 1'b0;
      end_ovl_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      from_err_q <= from_err_d;
      is_start_q <= is_start_d;
      end_ovl_q  <= end_ovl_d;
    end
  end

  assign isStart     = is_start_q;
  assign endOverload = end_ovl_q;

endmodule

// File: tb/tb_frame_maker_top.sv
// Directed-vector bench for frame_maker_top with hand-computed pulse expectations.
// Each step drives one bit, clocks one sample point, and checks both registered pulses.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
module tb_frame_maker_top;

  logic samplePoint = 1'b0;
  logic reset       = 1'b0;
  logic canRX       = 1'b1;
  logic frameReady  = 1'b0;
  logic isError     = 1'b0;
  logic endOverload;
  logic isStart;

  int n_vec = 0;
  int n_bad = 0;

  frame_maker_top #(
    .INTEG_BITS (11),
    .DELIM_BITS (8),
    .INTERM_BITS(3)
  ) dut (
    .samplePoint(samplePoint),
    .reset      (reset),
    .canRX      (canRX),
    .frameReady (frameReady),
    .isError    (isError),
    .endOverload(endOverload),
    .isStart    (isStart)
  );

  always #5 samplePoint = ~samplePoint;

  // Apply one bit, clock it in, then compare both outputs.
  task automatic step(input string tag, input logic rst, input logic rx, input logic fr,
                      input logic err, input logic exp_start, input logic exp_eovl);
    reset      = rst;
    canRX      = rx;
    frameReady = fr;
    isError    = err;
    @(posedge samplePoint);
    #1;
    n_vec++;
    assert (isStart === exp_start)
    else begin
      n_bad++;
      $error("FAIL %s isStart observed=%b expected=%b", tag, isStart, exp_start);
    end
    n_vec++;
    assert (endOverload === exp_eovl)
    else begin
      n_bad++;
      $error("FAIL %s endOverload observed=%b expected=%b", tag, endOverload, exp_eovl);
    end
  endtask

  initial begin
    @(posedge samplePoint);
    #1;

    // Reset, 11 recessive, then one dominant gives a single isStart.
    step("reset", 1, 1, 0, 0, 0, 0);
    repeat (11) step("integ11", 0, 1, 0, 0, 0, 0);
    step("sof_after_integ", 0, 0, 0, 0, 1, 0);
    step("sof_one_cycle", 0, 0, 0, 0, 0, 0);

    // 10 recessive then dominant restarts integration; 11 more needed.
    step("reset2", 1, 1, 0, 0, 0, 0);
    repeat (10) step("integ10", 0, 1, 0, 0, 0, 0);
    step("integ_break", 0, 0, 0, 0, 0, 0);
    repeat (10) step("integ_re10", 0, 1, 0, 0, 0, 0);
    step("integ_re11", 0, 1, 0, 0, 0, 0);
    step("sof_after_reinteg", 0, 0, 0, 0, 1, 0);

    // Frame end, 3 recessive intermission bits (frameReady held) -> IDLE, no pulse.
    step("frame_ready", 0, 1, 1, 0, 0, 0);
    repeat (3) step("interm_rec_fr_held", 0, 1, 1, 0, 0, 0);
    step("idle_fr_held", 0, 1, 1, 0, 0, 0);
    // isError ignored in IDLE.
    step("idle_err_ignored", 0, 1, 0, 1, 0, 0);
    step("sof_from_idle", 0, 0, 0, 0, 1, 0);
    step("frame_bit", 0, 1, 0, 0, 0, 0);

    // Overload: intermission bit 1 dominant, 6 dominant, 8 recessive.
    step("frame_ready_ovl", 0, 1, 1, 0, 0, 0);
    step("interm_bit1_dom", 0, 0, 0, 0, 0, 0);
    repeat (6) step("ovl_flag", 0, 0, 0, 0, 0, 0);
    repeat (7) step("ovl_delim", 0, 1, 0, 0, 0, 0);
    step("ovl_delim_end", 0, 1, 0, 0, 0, 1);
    step("post_ovl_interm1", 0, 1, 0, 0, 0, 0);
    step("post_ovl_interm2", 0, 1, 0, 0, 0, 0);
    step("post_ovl_interm3", 0, 1, 0, 0, 0, 0);
    step("sof_after_ovl", 0, 0, 0, 0, 1, 0);

    // Error beats frameReady: 12 dominant, 5 rec, 1 dom, 8 rec -> one endOverload.
    step("err_and_ready", 0, 0, 1, 1, 0, 0);
    repeat (12) step("err_flag", 0, 0, 0, 0, 0, 0);
    repeat (5) step("err_delim5", 0, 1, 0, 0, 0, 0);
    step("err_delim_broken", 0, 0, 0, 0, 0, 0);
    repeat (7) step("err_delim_re", 0, 1, 0, 0, 0, 0);
    step("err_delim_end", 0, 1, 0, 0, 0, 1);

    // Intermission rec, rec, dom -> start-of-frame.
    step("interm_r1", 0, 1, 0, 0, 0, 0);
    step("interm_r2", 0, 1, 0, 0, 0, 0);
    step("interm_bit3_sof", 0, 0, 0, 0, 1, 0);
    step("frame_after_bit3", 0, 1, 0, 0, 0, 0);

    // Intermission bit 2 dominant -> overload flag, delimiter completes.
    step("frame_ready_b2", 0, 1, 1, 0, 0, 0);
    step("interm_b2_r1", 0, 1, 0, 0, 0, 0);
    step("interm_bit2_dom", 0, 0, 0, 0, 0, 0);
    repeat (7) step("b2_delim", 0, 1, 0, 0, 0, 0);
    step("b2_delim_end", 0, 1, 0, 0, 0, 1);
    repeat (2) step("b2_interm", 0, 1, 0, 0, 0, 0);
    step("b2_sof", 0, 0, 0, 0, 1, 0);

    // isError in INTERMISSION forces an error flag and a delimiter.
    step("frame_ready_ie", 0, 1, 1, 0, 0, 0);
    step("interm_err", 0, 1, 0, 1, 0, 0);
    repeat (7) step("ie_delim", 0, 1, 0, 0, 0, 0);
    step("ie_delim_end", 0, 1, 0, 0, 0, 1);
    repeat (2) step("ie_interm", 0, 1, 0, 0, 0, 0);
    step("ie_sof", 0, 0, 0, 0, 1, 0);

    // Reset during delimiter after 5 recessive bits; integration restarts from 0.
    step("rst_err", 0, 0, 0, 1, 0, 0);
    repeat (2) step("rst_err_flag", 0, 0, 0, 0, 0, 0);
    repeat (5) step("rst_delim5", 0, 1, 0, 0, 0, 0);
    step("rst_mid_delim", 1, 1, 0, 0, 0, 0);
    repeat (3) step("rst_no_eovl", 0, 1, 0, 0, 0, 0);
    repeat (7) step("rst_integ", 0, 1, 0, 0, 0, 0);
    step("rst_integ_dom", 0, 0, 0, 0, 0, 0);
    repeat (11) step("rst_reinteg", 0, 1, 0, 0, 0, 0);
    step("rst_sof", 0, 0, 0, 0, 1, 0);

    // Reset mid-frame: no pulse, integration required again.
    step("midframe_bit", 0, 1, 0, 0, 0, 0);
    step("midframe_reset", 1, 0, 0, 0, 0, 0);
    step("midframe_dom", 0, 0, 0, 0, 0, 0);
    repeat (11) step("midframe_integ", 0, 1, 0, 0, 0, 0);
    step("midframe_sof", 0, 0, 0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
